weld_switch_sequencer: RTL and testbench

Sequences the welding power-stage IGBT around short-circuit neck events. It takes single-cycle neck-start and neck-end pulses from the derivative-based neck detector and drives `power_switch`. It enforces a post-re-enable blanking window and a hard maximum off-time, and it gates the detector through `en_judge`. It also provides a fixed-duty IGBT drive test mode and a latched fault shutdown. It sits between the neck detector and the IGBT gate-driver pin.

---
 rtl/weld_ctrl_pkg.sv | 21 ++
 rtl/weld_switch_sequencer_cycle_timer.sv | 48 ++++
 rtl/weld_switch_sequencer.sv | 132 +++++++++++++
 tb/tb_weld_switch_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/weld_ctrl_pkg.sv
// Shared weld-control definitions: sequencer state encoding and default cycle
// constants used by the neck detector, the switch sequencer and the top level.
package weld_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BLANK = 3'd1,
        ST_ARC   = 3'd2,
        ST_NECK  = 3'd3,
        ST_TEST  = 3'd4,
        ST_FAULT = 3'd5
    } weld_state_e;

    localparam int BLANK_CYC_DEF   = 100;
    localparam int MAX_OFF_CYC_DEF = 5000;
    localparam int PWM_PERIOD_DEF  = 2000;
    localparam int PWM_OFF_DEF     = 200;
    localparam int CNT_W_DEF       = 13;
    localparam int NECK_CNT_W      = 16;

endpackage

// File: rtl/weld_switch_sequencer_cycle_timer.sv
// Shared cycle counter with synchronous clear, count enable, terminal compare
// and optional wrap at the terminal value (otherwise it holds there).
module cycle_timer
    import weld_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             wrap_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             term_hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The next value is exported so the owner can decode registered outputs from it.
    always_comb begin
        term_hit_o = (cnt_q == term_i);
        cnt_d      = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (term_hit_o) begin
                if (wrap_i) begin
                    cnt_d = '0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_next_o = cnt_d;

endmodule

// File: rtl/weld_switch_sequencer.sv
// IGBT switch sequencer: arc blanking, neck off-time with timeout, fixed-duty
// drive test mode and latched fault shutdown. All outputs are registered.
module weld_switch_sequencer
    import weld_ctrl_pkg::*;
#(
    parameter int BLANK_CYC   = BLANK_CYC_DEF,
    parameter int MAX_OFF_CYC = MAX_OFF_CYC_DEF,
    parameter int PWM_PERIOD  = PWM_PERIOD_DEF,
    parameter int PWM_OFF     = PWM_OFF_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        mode_test,
    input  logic        neck_start,
    input  logic        neck_end,
    input  logic        fault_in,
    output logic        power_switch,
    output logic        en_judge,
    output logic        timeout_pulse,
    output logic [15:0] neck_count,
    output logic [2:0]  state_o
);

    localparam logic [CNT_W-1:0] BLANK_TERM = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] NECK_TERM  = CNT_W'(MAX_OFF_CYC - 1);
    localparam logic [CNT_W-1:0] PWM_TERM   = CNT_W'(PWM_PERIOD - 1);
    localparam logic [CNT_W-1:0] PWM_ON     = CNT_W'(PWM_PERIOD - PWM_OFF);

    weld_state_e      state_q, state_d;
    logic             power_switch_q, power_switch_d;
    logic             en_judge_q, en_judge_d;
    logic             timeout_q, timeout_d;
    logic [15:0]      neck_count_q, neck_count_d;
    logic             tmr_en, tmr_wrap, tmr_hit;
    logic [CNT_W-1:0] tmr_term, cnt_next;

    // Timer only counts in the timed states; any state change restarts it from 0.
    always_comb begin
        tmr_en   = (state_q == ST_BLANK) || (state_q == ST_NECK) || (state_q == ST_TEST);
        tmr_wrap = (state_q == ST_TEST);
        case (state_q)
            ST_BLANK: tmr_term = BLANK_TERM;
            ST_NECK:  tmr_term = NECK_TERM;
            ST_TEST:  tmr_term = PWM_TERM;
            default:  tmr_term = '0;
        endcase
    end

    cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (state_d != state_q),
        .en_i       (tmr_en),
        .wrap_i     (tmr_wrap),
        .term_i     (tmr_term),
        .cnt_next_o (cnt_next),
        .term_hit_o (tmr_hit)
    );

    // Fault overrides everything, then loss of enable, then per-state rules.
    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        if (fault_in) begin
            state_d = ST_FAULT;
        end else if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = mode_test ? ST_TEST : ST_BLANK;
                ST_BLANK: if (tmr_hit) state_d = ST_ARC;
                ST_ARC:   if (neck_start) state_d = ST_NECK;
                ST_NECK: begin
                    if (neck_end) begin
                        state_d = ST_BLANK;
                    end else if (tmr_hit) begin
                        state_d   = ST_BLANK;
                        timeout_d = 1'b1;
                    end
                end
                ST_TEST:  if (!mode_test) state_d = ST_IDLE;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decode from the next state so they move on the same edge as the state.
    always_comb begin
        power_switch_d = 1'b0;
        en_judge_d     = 1'b0;
        case (state_d)
            ST_BLANK: power_switch_d = 1'b1;
            ST_ARC: begin
                power_switch_d = 1'b1;
                en_judge_d     = 1'b1;
            end
            ST_NECK:  en_judge_d = 1'b1;
            ST_TEST:  power_switch_d = (cnt_next < PWM_ON);
            default:  power_switch_d = 1'b0;
        endcase
        neck_count_d = neck_count_q;
        if ((state_q == ST_ARC) && (state_d == ST_NECK) && (neck_count_q != 16'hFFFF)) begin
            neck_count_d = neck_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            power_switch_q <= 1'b0;
            en_judge_q     <= 1'b0;
            timeout_q      <= 1'b0;
            neck_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            power_switch_q <= power_switch_d;
            en_judge_q     <= en_judge_d;
            timeout_q      <= timeout_d;
            neck_count_q   <= neck_count_d;
        end
    end

    assign power_switch  = power_switch_q;
    assign en_judge      = en_judge_q;
    assign timeout_pulse = timeout_q;
    assign neck_count    = neck_count_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_weld_switch_sequencer.sv
// Directed bench for weld_switch_sequencer: a table of held input patterns with
// expected outputs after every cycle, plus hand-written async reset sequences.
module tb_weld_switch_sequencer;

    typedef struct {
        logic        en;
        logic        mode;
        logic        ns;
        logic        ne;
        logic        flt;
        int          rep;
        logic        ps;
        logic        ej;
        logic        tp;
        logic [2:0]  st;
        logic [15:0] nc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        mode_test = 1'b0;
    logic        neck_start = 1'b0;
    logic        neck_end = 1'b0;
    logic        fault_in = 1'b0;
    logic        power_switch;
    logic        en_judge;
    logic        timeout_pulse;
    logic [15:0] neck_count;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    weld_switch_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .mode_test     (mode_test),
        .neck_start    (neck_start),
        .neck_end      (neck_end),
        .fault_in      (fault_in),
        .power_switch  (power_switch),
        .en_judge      (en_judge),
        .timeout_pulse (timeout_pulse),
        .neck_count    (neck_count),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, mode, ns, ne, flt, input int rep,
                                input logic ps, ej, tp, input logic [2:0] st,
                                input logic [15:0] nc);
        vec_t v;
        v.en = en; v.mode = mode; v.ns = ns; v.ne = ne; v.flt = flt; v.rep = rep;
        v.ps = ps; v.ej = ej; v.tp = tp; v.st = st; v.nc = nc;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input int step, input vec_t v);
        checks++;
        if (power_switch !== v.ps || en_judge !== v.ej || timeout_pulse !== v.tp ||
            state_o !== v.st || neck_count !== v.nc) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got ps=%b ej=%b tp=%b st=%0d nc=%0d, want ps=%b ej=%b tp=%b st=%0d nc=%0d",
                     tag, step, power_switch, en_judge, timeout_pulse, state_o, neck_count,
                     v.ps, v.ej, v.tp, v.st, v.nc);
        end
    endtask

    task automatic applyStimulus(input string tag, input vec_t v);
        for (int r = 0; r < v.rep; r++) begin
            enable     = v.en;
            mode_test  = v.mode;
            neck_start = v.ns;
            neck_end   = v.ne;
            fault_in   = v.flt;
            @(posedge clk);
            #1;
            checkOutput(tag, r, v);
        end
    endtask

    initial begin
        // en mode ns ne flt rep | ps ej tp st nc
        vecs.push_back(mk(1,0,0,0,0, 100, 1,0,0,3'd1,16'd0));
        vecs.push_back(mk(1,0,0,0,0,   5, 1,1,0,3'd2,16'd0));
        vecs.push_back(mk(1,0,1,0,0,   1, 0,1,0,3'd3,16'd1));
        vecs.push_back(mk(1,0,0,0,0, 299, 0,1,0,3'd3,16'd1));
        vecs.push_back(mk(1,0,0,1,0,   1, 1,0,0,3'd1,16'd1));
        vecs.push_back(mk(1,0,0,0,0,  99, 1,0,0,3'd1,16'd1));
        vecs.push_back(mk(1,0,0,0,0,   1, 1,1,0,3'd2,16'd1));
        vecs.push_back(mk(1,0,0,1,0,   2, 1,1,0,3'd2,16'd1));
        vecs.push_back(mk(1,0,1,0,0,   1, 0,1,0,3'd3,16'd2));
        vecs.push_back(mk(1,0,1,0,0,   1, 0,1,0,3'd3,16'd2));
        vecs.push_back(mk(1,0,0,0,0,4998, 0,1,0,3'd3,16'd2));
        vecs.push_back(mk(1,0,0,0,0,   1, 1,0,1,3'd1,16'd2));
        vecs.push_back(mk(1,0,0,0,0,  99, 1,0,0,3'd1,16'd2));
        vecs.push_back(mk(1,0,0,0,0,   1, 1,1,0,3'd2,16'd2));
        vecs.push_back(mk(1,0,1,0,0,   1, 0,1,0,3'd3,16'd3));
        vecs.push_back(mk(1,0,0,0,0,4999, 0,1,0,3'd3,16'd3));
        vecs.push_back(mk(1,0,0,1,0,   1, 1,0,0,3'd1,16'd3));
        vecs.push_back(mk(1,0,0,0,0,  99, 1,0,0,3'd1,16'd3));
        vecs.push_back(mk(1,0,0,0,0,   1, 1,1,0,3'd2,16'd3));
        vecs.push_back(mk(1,0,0,0,1,   1, 0,0,0,3'd5,16'd3));
        vecs.push_back(mk(1,0,0,0,1,   2, 0,0,0,3'd5,16'd3));
        vecs.push_back(mk(1,0,0,0,0,   3, 0,0,0,3'd5,16'd3));
        vecs.push_back(mk(0,0,0,0,1,   2, 0,0,0,3'd5,16'd3));
        vecs.push_back(mk(0,0,0,0,0,   1, 0,0,0,3'd0,16'd3));
        vecs.push_back(mk(0,1,0,0,0,   2, 0,0,0,3'd0,16'd3));
        vecs.push_back(mk(1,1,0,0,0,1800, 1,0,0,3'd4,16'd3));
        vecs.push_back(mk(1,1,0,0,0, 200, 0,0,0,3'd4,16'd3));
        vecs.push_back(mk(1,1,0,0,0,1800, 1,0,0,3'd4,16'd3));
        vecs.push_back(mk(1,1,0,0,0,   3, 0,0,0,3'd4,16'd3));
        vecs.push_back(mk(1,0,0,0,0,   1, 0,0,0,3'd0,16'd3));
        vecs.push_back(mk(1,1,0,0,0,  10, 1,0,0,3'd4,16'd3));
        vecs.push_back(mk(1,1,0,0,1,   1, 0,0,0,3'd5,16'd3));
        vecs.push_back(mk(0,0,0,0,0,   1, 0,0,0,3'd0,16'd3));
        vecs.push_back(mk(1,0,0,0,0, 100, 1,0,0,3'd1,16'd3));
        vecs.push_back(mk(1,0,0,0,0,   1, 1,1,0,3'd2,16'd3));
        vecs.push_back(mk(0,0,0,0,0,   1, 0,0,0,3'd0,16'd3));
        vecs.push_back(mk(1,0,0,0,0,  50, 1,0,0,3'd1,16'd3));
        vecs.push_back(mk(0,0,0,0,0,   1, 0,0,0,3'd0,16'd3));
        vecs.push_back(mk(1,0,0,0,0, 100, 1,0,0,3'd1,16'd3));
        vecs.push_back(mk(1,0,0,0,0,   1, 1,1,0,3'd2,16'd3));

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", 0, mk(0,0,0,0,0,1, 0,0,0,3'd0,16'd0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset in the middle of a neck, no clock edge needed.
        applyStimulus("neckA", mk(1,0,1,0,0,  1, 0,1,0,3'd3,16'd4));
        applyStimulus("neckB", mk(1,0,0,0,0, 20, 0,1,0,3'd3,16'd4));
        #3 rst_n = 1'b0;
        #1 checkOutput("async_rst_neck", 0, mk(0,0,0,0,0,1, 0,0,0,3'd0,16'd0));
        @(posedge clk);
        #1 checkOutput("held_rst_neck", 0, mk(0,0,0,0,0,1, 0,0,0,3'd0,16'd0));
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a PWM on-phase.
        applyStimulus("pwm_on", mk(1,1,0,0,0, 30, 1,0,0,3'd4,16'd0));
        #3 rst_n = 1'b0;
        #1 checkOutput("async_rst_pwm", 0, mk(0,0,0,0,0,1, 0,0,0,3'd0,16'd0));
        @(negedge clk);
        enable    = 1'b0;
        mode_test = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1 checkOutput("post_rst_idle", 0, mk(0,0,0,0,0,1, 0,0,0,3'd0,16'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
